cache_ram_responder: RTL
========================

Name: cache_ram_responder

Overview:
- Main-memory side of the cache↔RAM interface.
- Accepts single-word strobed writes (write-through / write-back) and 4-beat line-refill reads from the cache top.
- Serves them from an internal word-addressed memory with programmable wait states.
- Returns refill data one 32-bit word per cycle, critical word first, plus handshake/status for the cache controller.

Parameters:
- ADDR_W, 32, byte-address width of the request ports.
- MEM_WORDS, 4096, depth of the internal 32-bit memory (power of two).
- READ_LAT, 4, cycles from read accept to first data beat (≥1).
- WRITE_LAT, 2, cycles from write accept to commit (≥1).
- BEATS, 4, words per refill burst (one 128-bit line).

Ports:
- clk_i  in  1  single clock; cache clock and memory clock are the same here.
- rst_ni  in  1  asynchronous, active-low reset.
- ram_read_i  in  1  read request, one-cycle pulse or level, sampled only while busy_o=0.
- ram_read_addr_i  in  ADDR_W  byte address of requested word; bits [1:0] ignored.
- write_data_i  in  1  write request, sampled only while busy_o=0.
- ram_write_addr_i  in  ADDR_W  byte address of write; bits [1:0] ignored.
- ram_data_i  in  32  write data.
- wr_strb_i  in  4  byte enables; bit n covers byte lane [8n+7:8n].
- ram_data_o  out  32  read beat data.
- ram_valid_o  out  1  ram_data_o holds a valid beat this cycle.
- ram_last_o  out  1  final beat of the burst; qualified by ram_valid_o.
- write_done_o  out  1  one-cycle pulse when a write commits.
- busy_o  out  1  request in progress; new requests are ignored.
- addr_err_o  out  1  one-cycle pulse when an accepted request is out of range.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0. Memory contents are not cleared by reset.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE accept:
  - write_data_i=1 → latch address, data and strobe; go to WR_WAIT. Write wins over a simultaneous read, so write-through data reaches memory before a refill.
  - Else ram_read_i=1 → latch the line base (addr[ADDR_W-1:4]) and start word addr[3:2]; go to RD_WAIT.
  - A read raised together with a write is dropped. The requester re-asserts it after busy_o falls.
- busy_o = 1 in every state except IDLE. It is registered, so it asserts the cycle after accept.
- RD_WAIT: count READ_LAT-1 cycles, then go to RD_BURST. The first beat therefore appears exactly READ_LAT cycles after the accept edge.
- RD_BURST:
  - ram_valid_o=1 for BEATS consecutive cycles.
  - Word index is start, start+1, … modulo BEATS, wrapping within the line: start=2 gives 2,3,0,1.
  - ram_last_o=1 on beat BEATS-1.
  - Return to IDLE on the cycle after the last beat.
- WR_WAIT: count WRITE_LAT cycles, then:
  - Commit only the strobed bytes, then pulse write_done_o for one cycle and return to IDLE.
  - wr_strb_i=0 commits nothing but still pulses write_done_o.
- Out of range (word address ≥ MEM_WORDS):
  - addr_err_o pulses on the cycle after accept.
  - A read still produces the full BEATS-beat burst with data 0.
  - A write is dropped, but write_done_o still pulses at the normal time.
- Back-to-back: a request held high through the return-to-IDLE cycle is accepted there. Minimum gap between accepts is READ_LAT+BEATS cycles (read) or WRITE_LAT+1 cycles (write).
- Reset mid-operation: immediate abort to IDLE with outputs 0. A write not yet committed is lost.
- Memory is a synchronous-read array; the read address is presented one cycle ahead so that beat data is registered.

Decomposition:
- Shared package cache_pkg:
  - FSM state enum.
  - Constants LINE_BYTES=16, WORD_BYTES=4, BEATS.
  - Address-slice helper functions (line base, word index).
- One sub-module, cache_ram_array: single-port synchronous SRAM with 4-bit byte-write enable and registered read. This lets the memory map onto block RAM.

Test Plan:
- Pre-load word[0x10..0x13]=A0..A3, READ_LAT=4; read pulse at 0x44 → 4 cycles later beats A1,A2,A3,A0 on consecutive cycles; ram_last_o with A0; busy_o drops after.
- Write 0xDEADBEEF to 0x100 with strb=0101, old value 0x11223344 → write_done_o 2 cycles after accept; readback of the line gives word 0x11AD33EF.
- Simultaneous write_data_i and ram_read_i to the same word 0x200 (old 0, data 0x55) → write completes first; read is dropped; a re-issued read returns 0x55.
- Read at 0x4000 with MEM_WORDS=4096 → addr_err_o pulse, 4 beats of 0, ram_last_o on the 4th. Write to the same address → addr_err_o and write_done_o, memory unchanged.
- Assert rst_ni=0 during beat 2 of a burst → ram_valid_o and busy_o go 0 immediately. After release, a new read is accepted and completes normally; memory is intact.
- Requests pulsed while busy_o=1 → ignored: no extra beats and no extra write_done_o.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, line geometry and address-slice helpers for the cache/RAM interface.
package cache_pkg;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BEATS      = LINE_BYTES / WORD_BYTES;
  // Helpers operate on a zero-extended address so any ADDR_W up to this width works.
  localparam int unsigned MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdBurst,
    StWrWait
  } state_e;

  // Byte address -> line number (address with the in-line offset dropped).
  function automatic logic [MAX_ADDR_W-1:0] line_base(input logic [MAX_ADDR_W-1:0] addr);
    return addr >> $clog2(LINE_BYTES);
  endfunction

  // Byte address -> word index within its line.
  function automatic logic [1:0] word_idx(input logic [MAX_ADDR_W-1:0] addr);
    return 2'(addr >> $clog2(WORD_BYTES));
  endfunction

endpackage

// File: rtl/cache_ram_array.sv
// Single-port 32-bit synchronous SRAM with byte-write enables and a registered read port.
// Deliberately has no reset so it can map onto block RAM.
module cache_ram_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write or registered read, one access per cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_ram_responder.sv
// Memory side of the cache<->RAM link: strobed single-word writes and wrapping
// critical-word-first line refills, each with a fixed programmable latency.
module cache_ram_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned WRITE_LAT = 2,
  parameter int unsigned BEATS     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ram_read_i,
  input  logic [ADDR_W-1:0] ram_read_addr_i,
  input  logic              write_data_i,
  input  logic [ADDR_W-1:0] ram_write_addr_i,
  input  logic [31:0]       ram_data_i,
  input  logic [3:0]        wr_strb_i,
  output logic [31:0]       ram_data_o,
  output logic              ram_valid_o,
  output logic              ram_last_o,
  output logic              write_done_o,
  output logic              busy_o,
  output logic              addr_err_o
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned LB_W  = AW - 2;
  localparam int unsigned CNT_W = $clog2(READ_LAT + WRITE_LAT + BEATS + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [LB_W-1:0]   line_q;
  logic [AW-1:0]     wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        wr_strb_q;
  logic              oor_q;
  logic              valid_q, valid_d, last_q, last_d;
  logic              done_q, done_d, err_q, err_d;
  logic              accept_rd, accept_wr;

  logic [MAX_ADDR_W-1:0] rd_line_full, wr_word_full;
  logic [1:0]            rd_start;
  logic                  rd_oor, wr_oor;

  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata;

  assign rd_line_full = line_base(MAX_ADDR_W'(ram_read_addr_i));
  assign rd_start     = word_idx(MAX_ADDR_W'(ram_read_addr_i));
  assign wr_word_full = MAX_ADDR_W'(ram_write_addr_i) >> 2;
  // Any set bit above the array index puts the request past the end of memory.
  assign rd_oor       = (rd_line_full >> LB_W) != '0;
  assign wr_oor       = (wr_word_full >> AW) != '0;

  // Next-state, memory control and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {line_q, idx_q};
    unique case (state_q)
      StIdle: begin
        // Write wins so write-through data lands before any refill of the same line.
        if (write_data_i) begin
          accept_wr = 1'b1;
          err_d     = wr_oor;
          cnt_d     = '0;
          state_d   = StWrWait;
        end else if (ram_read_i) begin
          accept_rd = 1'b1;
          err_d     = rd_oor;
          cnt_d     = '0;
          idx_d     = rd_start;
          state_d   = (READ_LAT == 1) ? StRdBurst : StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q == CNT_W'(READ_LAT - 2)) begin
          cnt_d   = '0;
          state_d = StRdBurst;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRdBurst: begin
        // Address issued here; the registered beat appears one cycle later.
        mem_en  = !oor_q;
        valid_d = 1'b1;
        idx_d   = idx_q + 2'd1;
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWrWait: begin
        if (cnt_q == CNT_W'(WRITE_LAT - 1)) begin
          mem_en   = !oor_q;
          mem_we   = 1'b1;
          mem_addr = wr_addr_q;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, request capture and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      line_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      oor_q     <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept_wr) begin
        wr_addr_q <= wr_word_full[AW-1:0];
        wr_data_q <= ram_data_i;
        wr_strb_q <= wr_strb_i;
        oor_q     <= wr_oor;
      end else if (accept_rd) begin
        line_q <= rd_line_full[LB_W-1:0];
        oor_q  <= rd_oor;
      end
    end
  end

  cache_ram_array #(
    .DEPTH (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (wr_strb_q),
    .addr_i  (mem_addr),
    .wdata_i (wr_data_q),
    .rdata_o (mem_rdata)
  );

  // Array output is not reset, so beats are gated; out-of-range refills return zeros.
  assign ram_data_o   = (valid_q && !oor_q) ? mem_rdata : '0;
  assign ram_valid_o  = valid_q;
  assign ram_last_o   = last_q;
  assign write_done_o = done_q;
  assign addr_err_o   = err_q;
  assign busy_o       = (state_q != StIdle);

endmodule
